single_cycle_cpu: RTL and testbench
===================================

# single_cycle_cpu

Single-cycle MIPS-subset processor: fetch, decode, execute, memory access and write-back all complete in one clock. It owns its instruction memory, register file and data memory, and has no external data ports. Benches preload memories and observe state through fixed hierarchical instance names. It is the top of the CPU design, driven only by clock, reset and a run-enable.

## Interface
- No parameters; sizes are fixed constants (see Structure).
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  run enable; 0 freezes all architectural state
- Required instance names, for bench access:
  - PC, with 32-bit output addr_o
  - InstrMem, with array memory[0:255] of 32 bits
  - RegFiles, with array register[0:31] of 32 bits
  - DataMem, with array memory[0:31] of 8 bits
  - Ctrl

## Operation
- Instruction fetch: InstrMem.memory[PC[9:2]], read combinationally. PC[1:0] ignored; index wraps at 256 words.
- Supported instructions, any other encoding executes as NOP with no state write:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08: sign-extended immediate.
  - lw 0x23, sw 0x2B.
  - beq 0x04.
  - j 0x02.
- Arithmetic: 32-bit two's-complement, wrap on overflow, no exceptions. slt is a signed compare, producing 1 or 0.
- Register 0 reads 0 always; writes to it are discarded.
- Data memory:
  - Byte array, little-endian word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - a = {addr[4:2], 2'b00}, so it is word-aligned and wraps at 32 bytes.
  - Load is combinational; store happens on clock edge.
- Next PC:
  - Default is PC+4.
  - beq taken gives PC+4+(sext(imm)<<2).
  - j gives {PC+4[31:28], target26, 2'b00}.

## Timing
- At each rising clk edge, rst=0 has highest priority:
  - PC <= 0.
  - All 32 registers <= 0.
  - Data and instruction memory are NOT cleared.
- With rst=1 and start=0: PC, registers and data memory hold; no writes occur.
- With rst=1 and start=1, the current instruction commits at the edge:
  - PC updates.
  - Register write-back (rd for R-type; rt for addi/lw) occurs.
  - sw writes memory.
- Latency: one instruction per cycle, CPI=1. A result is readable by the next instruction.
- Simultaneous read/write of the same register within a cycle: the read returns the old value, and the new value is visible after the edge.
- rst asserted mid-program: PC returns to 0 on that edge, and execution restarts from 0 after rst=1 and start=1.
- PC.addr_o after reset is 0 and advances by 4 per started cycle for straight-line code.

## Structure
- Shared package (cpu_pkg) holds:
  - Opcode and funct constants.
  - ALU-op enum.
  - Memory depth constants: IMEM_WORDS=256, DMEM_BYTES=32, NREGS=32.
- Sub-modules, one per instance name above:
  - pc_reg (PC)
  - instr_mem (InstrMem)
  - reg_file (RegFiles)
  - data_mem (DataMem)
  - control (Ctrl)
  - ALU kept inline or as alu.
- The natural single reusable sub-module is reg_file: 2 read ports, 1 write port, synchronous active-low clear.

## Test plan
- Reset: hold rst=0 for 1 edge. Required: PC.addr_o=0 and all registers=0. Then with start=0 for 3 cycles, PC stays 0.
- Straight-line ALU program: addi $8,$0,5; addi $9,$0,-3; add $10,$8,$9; sub $11,$8,$9; slt $12,$9,$8. Required: $10=2, $11=8, $12=1, and PC=20 after 5 cycles.
- Memory: preload DataMem bytes 0..3 = 05 00 00 00, then run:
  - lw $8,0($0) gives $8=5.
  - sw $8,4($0) gives bytes 4..7 = 05 00 00 00.
  - sw to address 36 writes bytes 4..7 (wrap).
- Branch/jump, from a program at address 0:
  - beq $0,$0,+2 at PC 8 gives PC 20.
  - beq with unequal operands gives PC+4.
  - j 0x10 gives PC 64.
- R0 and NOP: addi $0,$0,7 leaves $0=0. An all-zero-funct or unknown opcode only advances PC by 4.
- Mid-run reset: after 6 cycles, pulse rst=0 for one edge. Required: PC=0 and registers cleared, while DataMem contents are retained.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, ALU operation encoding and decode helpers for the single-cycle MIPS-subset CPU.
package cpu_pkg;

    localparam int IMEM_WORDS = 256;
    localparam int DMEM_BYTES = 32;
    localparam int NREGS      = 32;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Sign-extend a 16-bit immediate to a full data word.
    function automatic logic [31:0] sign_extend(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/control.sv
// Main decoder: maps opcode/funct to datapath controls; unsupported encodings decode as NOP.
module control
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       branch,
    output logic       jump,
    output logic [2:0] alu_op
);

    // Decode: everything defaults to a NOP with no state write.
    always_comb begin
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
                    FN_OR:   begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:  begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: reg_write = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// 32-byte little-endian data memory, word-aligned access, combinational load, clocked store.
module data_mem
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0] memory [0:DMEM_BYTES-1];

    // Store: write the four bytes of the addressed word, least significant byte lowest.
    always_ff @(posedge clk) begin
        if (we) begin
            memory[{addr, 2'b00}] <= wdata[7:0];
            memory[{addr, 2'b01}] <= wdata[15:8];
            memory[{addr, 2'b10}] <= wdata[23:16];
            memory[{addr, 2'b11}] <= wdata[31:24];
        end
    end

    assign rdata = {memory[{addr, 2'b11}], memory[{addr, 2'b10}],
                    memory[{addr, 2'b01}], memory[{addr, 2'b00}]};

endmodule

// File: rtl/instr_mem.sv
// Word-addressed instruction ROM with an optional program-load port; read is combinational.
module instr_mem
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] memory [0:IMEM_WORDS-1];

    // Program load: only used when an image is written in through the load port.
    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

    assign rdata = memory[raddr];

endmodule

// File: rtl/pc_reg.sv
// Program counter: cleared by reset, advances only while the core is enabled.
module pc_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] next_addr,
    output logic [31:0] addr_o
);

    logic [31:0] addr_r;

    // PC register: reset wins, otherwise load the next address when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r <= 32'd0;
        end else if (en) begin
            addr_r <= next_addr;
        end
    end

    assign addr_o = addr_r;

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port, synchronous active-low clear.
module reg_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] register [0:NREGS-1];

    // Register storage: clear everything on reset, otherwise write, never touching $0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                register[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            register[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge value; $0 is hardwired to zero.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : register[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : register[raddr2];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset core: fetch, decode, execute, memory and write-back complete each clock.
module single_cycle_cpu
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start
);

    logic [31:0] pc_s, pc_plus4_s, next_pc_s, instr_s;
    logic [31:0] rdata1_s, rdata2_s, imm_ext_s, alu_b_s, alu_result_s;
    logic [31:0] mem_rdata_s, wb_data_s, branch_target_s, jump_target_s;
    logic [4:0]  wb_addr_s;
    logic        reg_write_s, reg_dst_s, alu_src_s, mem_to_reg_s;
    logic        mem_write_s, branch_s, jump_s;
    logic [2:0]  alu_op_s;

    pc_reg PC (
        .clk       (clk),
        .rst       (rst),
        .en        (start),
        .next_addr (next_pc_s),
        .addr_o    (pc_s)
    );

    // The load port is unused in-system; images are placed in memory before reset.
    instr_mem InstrMem (
        .clk   (clk),
        .we    (1'b0),
        .waddr (8'd0),
        .wdata (32'd0),
        .raddr (pc_s[9:2]),
        .rdata (instr_s)
    );

    control Ctrl (
        .opcode     (instr_s[31:26]),
        .funct      (instr_s[5:0]),
        .reg_write  (reg_write_s),
        .reg_dst    (reg_dst_s),
        .alu_src    (alu_src_s),
        .mem_to_reg (mem_to_reg_s),
        .mem_write  (mem_write_s),
        .branch     (branch_s),
        .jump       (jump_s),
        .alu_op     (alu_op_s)
    );

    reg_file RegFiles (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write_s & start),
        .waddr  (wb_addr_s),
        .wdata  (wb_data_s),
        .raddr1 (instr_s[25:21]),
        .raddr2 (instr_s[20:16]),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s)
    );

    // Stores are suppressed while reset is held so memory is never disturbed by reset.
    data_mem DataMem (
        .clk   (clk),
        .we    (mem_write_s & start & rst),
        .addr  (alu_result_s[4:2]),
        .wdata (rdata2_s),
        .rdata (mem_rdata_s)
    );

    assign pc_plus4_s      = pc_s + 32'd4;
    assign imm_ext_s       = sign_extend(instr_s[15:0]);
    assign alu_b_s         = alu_src_s ? imm_ext_s : rdata2_s;
    assign wb_addr_s       = reg_dst_s ? instr_s[15:11] : instr_s[20:16];
    assign wb_data_s       = mem_to_reg_s ? mem_rdata_s : alu_result_s;
    assign branch_target_s = pc_plus4_s + (imm_ext_s << 2);
    assign jump_target_s   = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};

    // ALU: wrapping two's-complement arithmetic, bitwise logic, signed set-less-than.
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_op_e'(alu_op_s))
            ALU_ADD: alu_result_s = rdata1_s + alu_b_s;
            ALU_SUB: alu_result_s = rdata1_s - alu_b_s;
            ALU_AND: alu_result_s = rdata1_s & alu_b_s;
            ALU_OR:  alu_result_s = rdata1_s | alu_b_s;
            ALU_SLT: alu_result_s = ($signed(rdata1_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            default: alu_result_s = 32'd0;
        endcase
    end

    // Next-PC select: jump, then taken beq, otherwise sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (jump_s) begin
            next_pc_s = jump_target_s;
        end else if (branch_s && (rdata1_s == rdata2_s)) begin
            next_pc_s = branch_target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed self-checking bench for single_cycle_cpu using hierarchical preload/observation.
module tb_single_cycle_cpu;

    logic clk;
    logic rst;
    logic start;
    int   checks;
    int   errors;

    single_cycle_cpu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [4:0] a, b, d;
        a = 5'(rs); b = 5'(rt); d = 5'(rd);
        return {6'h00, a, b, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] a, b;
        a = 5'(rs); b = 5'(rt);
        return {op, a, b, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.InstrMem.memory[i] = 32'd0;
    endtask

    task automatic load_alu_prog();
        clear_imem();
        dut.InstrMem.memory[0] = i_ins(6'h08, 0, 8, 16'd5);
        dut.InstrMem.memory[1] = i_ins(6'h08, 0, 9, 16'hFFFD);
        dut.InstrMem.memory[2] = r_ins(8, 9, 10, 6'h20);
        dut.InstrMem.memory[3] = r_ins(8, 9, 11, 6'h22);
        dut.InstrMem.memory[4] = r_ins(9, 8, 12, 6'h2A);
        dut.InstrMem.memory[5] = r_ins(8, 9, 13, 6'h24);
        dut.InstrMem.memory[6] = r_ins(8, 9, 14, 6'h25);
        dut.InstrMem.memory[7] = r_ins(8, 9, 15, 6'h2A);
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] dword(input int w);
        return {dut.DataMem.memory[4*w+3], dut.DataMem.memory[4*w+2],
                dut.DataMem.memory[4*w+1], dut.DataMem.memory[4*w]};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;

        // Reset state and stall
        load_alu_prog();
        for (int i = 0; i < 32; i++) dut.DataMem.memory[i] = 8'h00;
        tick(1);
        check("reset_pc", dut.PC.addr_o, 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_r%0d", i), dut.RegFiles.register[i], 32'd0);
        rst = 1'b1; start = 1'b0;
        tick(3);
        check("stall_pc", dut.PC.addr_o, 32'd0);
        check("stall_r8", dut.RegFiles.register[8], 32'd0);

        // Straight-line ALU program
        start = 1'b1;
        tick(5);
        check("alu_r8", dut.RegFiles.register[8], 32'd5);
        check("alu_r9", dut.RegFiles.register[9], 32'hFFFF_FFFD);
        check("alu_add", dut.RegFiles.register[10], 32'd2);
        check("alu_sub", dut.RegFiles.register[11], 32'd8);
        check("alu_slt_true", dut.RegFiles.register[12], 32'd1);
        check("alu_pc20", dut.PC.addr_o, 32'd20);
        tick(3);
        check("alu_and", dut.RegFiles.register[13], 32'd5);
        check("alu_or", dut.RegFiles.register[14], 32'hFFFF_FFFD);
        check("alu_slt_false", dut.RegFiles.register[15], 32'd0);
        check("alu_pc32", dut.PC.addr_o, 32'd32);
        start = 1'b0;
        tick(2);
        check("hold_pc", dut.PC.addr_o, 32'd32);

        // Memory: load, store, wrapped store
        clear_imem();
        dut.InstrMem.memory[0] = i_ins(6'h23, 0, 8, 16'd0);
        dut.InstrMem.memory[1] = i_ins(6'h2B, 0, 8, 16'd4);
        dut.InstrMem.memory[2] = i_ins(6'h08, 0, 9, 16'h0077);
        dut.InstrMem.memory[3] = i_ins(6'h2B, 0, 9, 16'd36);
        dut.InstrMem.memory[4] = i_ins(6'h23, 0, 10, 16'd4);
        dut.DataMem.memory[0] = 8'h05;
        do_reset();
        start = 1'b1;
        tick(1);
        check("lw_r8", dut.RegFiles.register[8], 32'd5);
        tick(1);
        check("sw_word1", dword(1), 32'h0000_0005);
        tick(2);
        check("sw_wrap_word1", dword(1), 32'h0000_0077);
        check("sw_word0_kept", dword(0), 32'h0000_0005);
        tick(1);
        check("lw_r10", dut.RegFiles.register[10], 32'h0000_0077);
        check("mem_pc20", dut.PC.addr_o, 32'd20);

        // Branch, jump, $0 and NOPs
        clear_imem();
        dut.InstrMem.memory[0]  = i_ins(6'h08, 0, 8, 16'd1);
        dut.InstrMem.memory[1]  = i_ins(6'h08, 0, 9, 16'd2);
        dut.InstrMem.memory[2]  = i_ins(6'h04, 0, 0, 16'd2);
        dut.InstrMem.memory[3]  = i_ins(6'h08, 0, 10, 16'h0055);
        dut.InstrMem.memory[4]  = i_ins(6'h08, 0, 10, 16'h0066);
        dut.InstrMem.memory[5]  = i_ins(6'h04, 8, 9, 16'd5);
        dut.InstrMem.memory[6]  = {6'h02, 26'h10};
        dut.InstrMem.memory[16] = i_ins(6'h08, 0, 0, 16'd7);
        dut.InstrMem.memory[17] = r_ins(8, 9, 11, 6'h00);
        dut.InstrMem.memory[18] = i_ins(6'h3F, 8, 12, 16'h1234);
        do_reset();
        start = 1'b1;
        tick(3);
        check("beq_taken_pc", dut.PC.addr_o, 32'd20);
        tick(1);
        check("beq_not_taken_pc", dut.PC.addr_o, 32'd24);
        check("beq_skip_r10", dut.RegFiles.register[10], 32'd0);
        tick(1);
        check("j_pc", dut.PC.addr_o, 32'd64);
        tick(1);
        check("r0_zero", dut.RegFiles.register[0], 32'd0);
        check("r0_pc", dut.PC.addr_o, 32'd68);
        tick(1);
        check("nop_funct_r11", dut.RegFiles.register[11], 32'd0);
        check("nop_funct_pc", dut.PC.addr_o, 32'd72);
        tick(1);
        check("nop_op_r12", dut.RegFiles.register[12], 32'd0);
        check("nop_op_pc", dut.PC.addr_o, 32'd76);
        check("nop_mem_word1", dword(1), 32'h0000_0077);

        // Mid-run reset
        load_alu_prog();
        do_reset();
        start = 1'b1;
        tick(6);
        check("mid_pre_pc", dut.PC.addr_o, 32'd24);
        check("mid_pre_r13", dut.RegFiles.register[13], 32'd5);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        start = 1'b0;
        check("mid_pc", dut.PC.addr_o, 32'd0);
        for (int i = 8; i < 16; i++) check($sformatf("mid_r%0d", i), dut.RegFiles.register[i], 32'd0);
        check("mid_mem_word0", dword(0), 32'h0000_0005);
        check("mid_mem_word1", dword(1), 32'h0000_0077);
        start = 1'b1;
        tick(1);
        check("restart_r8", dut.RegFiles.register[8], 32'd5);
        check("restart_pc", dut.PC.addr_o, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
